prog_loader: RTL
================

# prog_loader

Sequencing controller that sits between a host word stream and the micro-MIPS shell's instruction-memory write port and reset input. It loads a program of `len` words into instruction memory starting at `BASE_ADR`, holds the core in reset for a fixed settling window, then releases the core for a bounded (or unbounded) number of cycles. It replaces hand-driven `mem_in`/`mem_adr`/`instr_en`/`res` sequencing.

## Interface

Parameters:
- `DEPTH`, 256: instruction memory size in words; maximum legal `len`.
- `LEN_W`, 9: width of `len`; must hold `DEPTH`.
- `BASE_ADR`, 0: word address of the first loaded instruction.
- `HOLD_CYCLES`, 2: cycles the core stays in reset after the last write; ≥1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `res` in 1: synchronous, active-low reset.
- `start` in 1: begins a session; sampled only in IDLE.
- `abort` in 1: cancels any session.
- `len` in LEN_W: number of words to load; latched on `start`.
- `run_cycles` in 32: core run budget in cycles; 0 means run until abort; latched on `start`.
- `host_valid` in 1: host word available.
- `host_data` in 32: host instruction word.
- `host_ready` out 1: loader accepts a word; a beat transfers on `host_valid && host_ready`.
- `mem_in` out 32: instruction word to memory.
- `mem_adr` out 32: word address to memory.
- `instr_en` out 1: memory write enable, one cycle per word.
- `core_res` out 1: active-low reset to the shell.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the run budget expires.
- `err` out 1: sticky flag for an illegal `len`.

## Operation

- States: IDLE, LOAD, HOLD, RUN.
- Reset (`res`=0 at an edge): state IDLE; `mem_in`=0, `mem_adr`=0, `instr_en`=0, `core_res`=0, `done`=0, `err`=0; internal counters 0. `host_ready` and `busy` are 0 because they decode from IDLE.
- IDLE: `core_res`=0.
  - On `start` with 1 ≤ `len` ≤ DEPTH: latch `len` and `run_cycles`, clear `err`, go to LOAD.
  - On `start` with `len`=0 or `len`>DEPTH: set `err`, stay in IDLE.
- LOAD: `host_ready`=1, combinationally decoded from state.
  - On each beat: `mem_in`<=`host_data`, `mem_adr`<=`BASE_ADR`+idx, `instr_en`<=1, idx increments.
  - With no beat: `instr_en`<=0 and `mem_in`/`mem_adr` hold.
  - The beat at idx = len−1 moves the state to HOLD.
- HOLD: `instr_en`<=0, `core_res`=0. After HOLD_CYCLES cycles, `core_res`<=1 and the state moves to RUN.
- RUN: the cycle counter increments each cycle.
  - With `run_cycles`≠0: when the count reaches `run_cycles`, `core_res`<=0, `done`<=1 for one cycle, and the state returns to IDLE.
  - With `run_cycles`=0: RUN never expires.
- `abort` (any non-IDLE state): the next state is IDLE, `instr_en`<=0, `core_res`<=0, no `done`, `err` unchanged. `abort` has priority over a simultaneous beat, which is not written.
- `start` outside IDLE is ignored.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. The counters are 32-bit, so `run_cycles`=0xFFFFFFFF is a legal finite budget.

## Timing

- Edge 0 samples `start`; `host_ready` is high from the following cycle.
- With `host_valid` held high, beats land on edges 1..N for N=`len`. Write k is visible on `mem_in`/`mem_adr`/`instr_en` in the cycle after edge k+1, so memory captures it on edge k+2.
- HOLD is entered at edge N. `core_res` rises at edge N+HOLD_CYCLES.
- `core_res` stays high for exactly `run_cycles` cycles. It falls, together with `done` rising, at edge N+HOLD_CYCLES+`run_cycles`.
- Gaps in `host_valid` stretch LOAD by one cycle per idle cycle and change nothing else.
- `res` low mid-session forces the full reset values at that edge regardless of state.

## Test plan

- Load 7 words starting 0x2009000B with `len`=7, BASE_ADR=0, `run_cycles`=100, `host_valid` continuous:
  - exactly 7 `instr_en` pulses at addresses 0..6 carrying the host data;
  - `core_res` rises at edge 9 and stays high for 100 cycles;
  - `done` pulses once; `busy` falls the same cycle.
- Same load with `host_valid` toggling 1,0,1,0…: addresses are still 0..6 in order, `instr_en` is low in gap cycles, and `core_res` rises 2 cycles after the 7th beat.
- `start` with `len`=0, then with `len`=257: `err`=1, `busy` stays 0, no `instr_en`. A following `start` with `len`=1 clears `err`.
- `abort` on the 4th beat of a 7-word load: that word is not written, the state is IDLE the next cycle, `core_res`=0, and `done` never pulses.
- `run_cycles`=0: `core_res` stays high for 1000+ cycles with no `done`. `abort` drops `core_res` on the next edge.
- `res` driven low during RUN: at the next edge all outputs take their reset values. `start` pulsed during RUN is ignored.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: loads a host word stream into instruction memory, holds the
// core in reset for a settling window, then runs it for a bounded budget.
module prog_loader #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned LEN_W       = 9,
  parameter logic [31:0] BASE_ADR    = 32'd0,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      run_cycles,
  input  logic             host_valid,
  input  logic [31:0]      host_data,
  output logic             host_ready,
  output logic [31:0]      mem_in,
  output logic [31:0]      mem_adr,
  output logic             instr_en,
  output logic             core_res,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      run_q, run_d;
  logic [31:0]      idx_q, idx_d;
  logic [31:0]      hold_q, hold_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      mem_in_q, mem_in_d;
  logic [31:0]      mem_adr_q, mem_adr_d;
  logic             instr_en_q, instr_en_d;
  logic             core_res_q, core_res_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             len_ok;
  logic [31:0]      cnt_inc;

  assign len_ok  = (len != '0) && (32'(len) <= DEPTH);
  assign cnt_inc = cnt_q + 32'd1;

  // Next-state and next-output decode for the load/hold/run sequence.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    run_d      = run_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    mem_in_d   = mem_in_q;
    mem_adr_d  = mem_adr_q;
    instr_en_d = 1'b0;
    core_res_d = core_res_q;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        core_res_d = 1'b0;
        if (start) begin
          if (len_ok) begin
            len_d   = len;
            run_d   = run_cycles;
            err_d   = 1'b0;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (host_valid) begin
          mem_in_d   = host_data;
          mem_adr_d  = BASE_ADR + idx_q;
          instr_en_d = 1'b1;
          idx_d      = idx_q + 32'd1;
          if (idx_q == 32'(len_q) - 32'd1) begin
            hold_d  = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == 32'(HOLD_CYCLES - 1)) begin
          core_res_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_RUN;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (run_q != '0 && cnt_inc == run_q) begin
          core_res_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the state decode chose, including a beat
    // arriving on the same edge: memory outputs keep their previous word.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      idx_d      = idx_q;
      mem_in_d   = mem_in_q;
      mem_adr_d  = mem_adr_q;
      instr_en_d = 1'b0;
      core_res_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      run_q      <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      mem_in_q   <= '0;
      mem_adr_q  <= '0;
      instr_en_q <= 1'b0;
      core_res_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      run_q      <= run_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      mem_in_q   <= mem_in_d;
      mem_adr_q  <= mem_adr_d;
      instr_en_q <= instr_en_d;
      core_res_q <= core_res_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign host_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign mem_in     = mem_in_q;
  assign mem_adr    = mem_adr_q;
  assign instr_en   = instr_en_q;
  assign core_res   = core_res_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
